// File: rtl/lif_neuron_if.sv
// lif_neuron_if: timestep strobe, input current and neuron outputs for one lif_neuron.
interface lif_neuron_if #(
    parameter int VW = 8
);
    logic                 enable;
    logic signed [1:0]    input_current;
    logic                 spike_out;
    logic signed [VW-1:0] membrane_potential;
    logic                 in_refractory;

    modport master (
        output enable, input_current,
        input  spike_out, membrane_potential, in_refractory
    );

    modport slave (
        input  enable, input_current,
        output spike_out, membrane_potential, in_refractory
    );
endinterface

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with saturating potential and refractory period.
// Define ADAPTIVE_THRESHOLD_EN to make the firing threshold rise per spike and decay back.
module lif_neuron #(
    parameter int VW             = 8,
    parameter int THRESHOLD      = 4,
    parameter int V_RESET        = 0,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 2,
    parameter int THR_STEP       = 2
) (
    input logic         clk,
    input logic         reset,
    lif_neuron_if.slave bus
);
    localparam int W  = VW + 2;
    localparam int CW = REFRACT_CYCLES > 0 ? $clog2(REFRACT_CYCLES + 1) : 1;
    localparam logic signed [W-1:0] MAXW = W'((1 << (VW - 1)) - 1);
    localparam logic signed [W-1:0] MINW = ~MAXW;

    typedef enum logic {INTEGRATE, REFRACT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [VW-1:0] v;
    logic signed [VW-1:0] thr;
    logic signed [VW-1:0] lk;
    logic signed [VW-1:0] v_sat;
    logic signed [W-1:0]  sum;
    logic                 spike;
    logic                 fire;

    // Widened by two bits so leak removal plus current can never wrap before clamping.
    always_comb begin
        lk    = v >>> LEAK_SHIFT;
        sum   = $signed({{2{v[VW-1]}}, v}) - $signed({{2{lk[VW-1]}}, lk})
              + $signed({{(W-2){bus.input_current[1]}}, bus.input_current});
        v_sat = sum > MAXW ? MAXW[VW-1:0] : sum < MINW ? MINW[VW-1:0] : sum[VW-1:0];
        fire  = v_sat >= thr;
    end

`ifdef ADAPTIVE_THRESHOLD_EN
    logic signed [W-1:0] thr_up;

    assign thr_up = $signed({{2{thr[VW-1]}}, thr}) + $signed(W'(THR_STEP));

    always_ff @(posedge clk) begin
        if (!reset)
            thr <= VW'(THRESHOLD);
        else if (bus.enable && state == INTEGRATE)
            thr <= fire ? (thr_up > MAXW ? MAXW[VW-1:0] : thr_up[VW-1:0])
                        : (thr > $signed(VW'(THRESHOLD)) ? thr - 1'b1 : thr);
    end
`else
    assign thr = VW'(THRESHOLD);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INTEGRATE;
            cnt   <= '0;
            v     <= VW'(V_RESET);
            spike <= 1'b0;
        end else begin
            spike <= 1'b0;
            if (bus.enable) begin
                if (state == INTEGRATE) begin
                    if (fire) begin
                        spike <= 1'b1;
                        v     <= VW'(V_RESET);
                        if (REFRACT_CYCLES > 0) begin
                            state <= REFRACT;
                            cnt   <= CW'(REFRACT_CYCLES);
                        end
                    end else begin
                        v <= v_sat;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= INTEGRATE;
                end
            end
        end
    end

    assign bus.spike_out          = spike;
    assign bus.membrane_potential = v;
    assign bus.in_refractory      = state == REFRACT;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed and random checks of lif_neuron against an integer reference model.
module tb_lif_neuron;
    localparam int VW             = 8;
    localparam int THRESHOLD      = 4;
    localparam int V_RESET        = 0;
    localparam int LEAK_SHIFT     = 3;
    localparam int REFRACT_CYCLES = 2;
    localparam int THR_STEP       = 2;
    localparam int VMAX           = (1 << (VW - 1)) - 1;
    localparam int VMIN           = -(1 << (VW - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int m_v = V_RESET;
    int m_thr = THRESHOLD;
    int m_cnt = 0;
    int m_spk = 0;
    int nsp;

    always #5 clk = ~clk;

    lif_neuron_if #(.VW(VW)) bus ();

    lif_neuron #(
        .VW(VW), .THRESHOLD(THRESHOLD), .V_RESET(V_RESET), .LEAK_SHIFT(LEAK_SHIFT),
        .REFRACT_CYCLES(REFRACT_CYCLES), .THR_STEP(THR_STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic int floor_div(int a);
        int d = 1 << LEAK_SHIFT;
        return a >= 0 ? a / d : -((-a + d - 1) / d);
    endfunction

    // Reference: refractory tracked as "timesteps still to skip", potential as a plain integer.
    task automatic model(input bit rst_n, input bit en, input int cur);
        int n;
        if (!rst_n) begin
            m_v = V_RESET; m_thr = THRESHOLD; m_cnt = 0; m_spk = 0;
        end else begin
            m_spk = 0;
            if (en) begin
                if (m_cnt > 0) begin
                    m_cnt--;
                end else begin
                    n = m_v - floor_div(m_v) + cur;
                    n = n > VMAX ? VMAX : n < VMIN ? VMIN : n;
                    if (n >= m_thr) begin
                        m_spk = 1; m_v = V_RESET; m_cnt = REFRACT_CYCLES;
`ifdef ADAPTIVE_THRESHOLD_EN
                        m_thr = m_thr + THR_STEP > VMAX ? VMAX : m_thr + THR_STEP;
`endif
                    end else begin
                        m_v = n;
`ifdef ADAPTIVE_THRESHOLD_EN
                        if (m_thr > THRESHOLD) m_thr--;
`endif
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst_n, input bit en, input logic [1:0] cur);
        reset = rst_n;
        bus.enable = en;
        bus.input_current = cur;
        @(posedge clk);
        model(rst_n, en, cur[1] ? int'(cur) - 4 : int'(cur));
        #1;
        check("spike", int'(bus.spike_out), m_spk);
        check("v", int'(bus.membrane_potential), m_v);
        check("refr", int'(bus.in_refractory), int'(m_cnt > 0));
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.input_current = 2'b01;
        cycle(0, 1, 2'b01);
        cycle(0, 1, 2'b01);
        check("rst_v", int'(bus.membrane_potential), 0);
        check("rst_spike", int'(bus.spike_out), 0);
        check("rst_refr", int'(bus.in_refractory), 0);

        repeat (3) cycle(1, 1, 2'b01);
        check("ramp_v3", int'(bus.membrane_potential), 3);
        cycle(1, 1, 2'b01);
        check("spike1", int'(bus.spike_out), 1);
        check("spike1_v", int'(bus.membrane_potential), 0);
        check("spike1_refr", int'(bus.in_refractory), 1);
        cycle(1, 1, 2'b01);
        check("refr_a", int'(bus.in_refractory), 1);
        check("refr_a_spike", int'(bus.spike_out), 0);
        cycle(1, 1, 2'b01);
        check("refr_end", int'(bus.in_refractory), 0);
        check("refr_end_v", int'(bus.membrane_potential), 0);
        repeat (3) cycle(1, 1, 2'b01);
        check("ramp2_v3", int'(bus.membrane_potential), 3);
        cycle(1, 1, 2'b01);
        check("spike2", int'(bus.spike_out), 1);

        cycle(1, 1, 2'b01);
        check("mid_refr", int'(bus.in_refractory), 1);
        cycle(0, 1, 2'b01);
        check("mid_rst_refr", int'(bus.in_refractory), 0);
        check("mid_rst_v", int'(bus.membrane_potential), 0);
        cycle(1, 1, 2'b01);
        check("mid_rst_resume", int'(bus.membrane_potential), 1);

        cycle(0, 1, 2'b10);
        repeat (12) cycle(1, 1, 2'b10);
        check("neg_hold", int'(bus.membrane_potential), -9);
        check("neg_nospike", int'(bus.spike_out), 0);

        cycle(0, 1, 2'b01);
        nsp = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, i % 3 == 2, 2'b01);
            nsp += int'(bus.spike_out);
        end
        check("tog_spike", int'(bus.spike_out), 1);
        cycle(1, 0, 2'b01);
        check("tog_pulse", int'(bus.spike_out), 0);
        check("tog_count", nsp, 1);

        repeat (400) cycle($urandom_range(49) != 0, $urandom_range(3) != 0, 2'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron stage, directly downstream of the input current calculator.
- Consumes the registered 2-bit signed `input_current` once per enabled timestep.
- Integrates it into a saturating signed membrane potential with shift-based leak, emits a one-cycle spike on threshold crossing, then enforces a refractory period.
- Spike output feeds the next layer's delay/spike fabric.

Parameters:
- VW, 8, membrane potential width (signed), min 4.
- THRESHOLD, 4, signed firing threshold; fire when v_next >= THRESHOLD.
- V_RESET, 0, signed potential loaded after a spike.
- LEAK_SHIFT, 3, leak = v >>> LEAK_SHIFT (arithmetic), range 1..VW-1.
- REFRACT_CYCLES, 2, enabled timesteps ignored after a spike; 0 = no refractory.
- THR_STEP, 2, threshold increment per spike (only with ADAPTIVE_THRESHOLD_EN).

Ports:
- clk, input, 1, clock, all state on rising edge.
- reset, input, 1, synchronous reset, active-low.
- enable, input, 1, timestep strobe; state advances only when high.
- input_current, input, 2, signed two's-complement current (-2..+1).
- spike_out, output, 1, one-cycle spike pulse.
- membrane_potential, output, VW, signed membrane potential register.
- in_refractory, output, 1, high while in REFRACT state.

Behaviour:
- Reset (`reset`=0 at clk edge): membrane_potential=V_RESET, spike_out=0, in_refractory=0, state=INTEGRATE, refractory counter=0, threshold reg=THRESHOLD. Reset wins over enable and over all in-flight operation, including mid-refractory.
- States:
  - INTEGRATE: normal accumulation.
  - REFRACT: input ignored, v held at V_RESET.
- enable=0: all state held; spike_out driven 0 on the next edge, so a spike is never longer than one cycle.
- INTEGRATE, enable=1:
  - Compute v_next = v - (v >>> LEAK_SHIFT) + sext(input_current) in VW+2 bits.
  - Saturate v_next to [-2^(VW-1), 2^(VW-1)-1].
  - If v_next >= threshold: spike_out<=1, v<=V_RESET. If REFRACT_CYCLES>0, go to REFRACT with counter<=REFRACT_CYCLES; otherwise stay in INTEGRATE.
  - Else: v<=v_next, spike_out<=0.
- REFRACT, enable=1: counter decrements, v held, spike_out<=0. When counter reaches 1 it decrements to 0 and the state returns to INTEGRATE; integration resumes on the following enabled cycle.
- in_refractory = (state==REFRACT), registered.
- Latency: spike_out and the new membrane_potential are visible one clk after the enabled edge that sampled input_current.
- Leak rounds toward -inf (arithmetic shift); negative potentials can settle at a nonzero fixed point, which is legal.
- Saturation comparison is made before the threshold compare.

Optional Feature:
- ADAPTIVE_THRESHOLD_EN defined:
  - Threshold register starts at THRESHOLD.
  - Each spike adds THR_STEP, saturating at 2^(VW-1)-1.
  - Every enabled INTEGRATE cycle without a spike decrements it by 1, not below THRESHOLD.
  - The firing compare uses the register.
- Not defined: threshold is the constant THRESHOLD, no extra register. Ports are identical in both builds.

Test Plan:
- Defaults; reset=0 for 2 clks with enable=1, input=01 -> membrane_potential=0, spike_out=0, in_refractory=0.
- Defaults; enable=1, input=01 every cycle -> v = 1, 2, 3, then spike_out=1 for exactly one cycle after the 4th enabled edge, v=0.
- Continue from the previous case -> in_refractory=1 for 2 enabled cycles with v=0, then v = 1, 2, 3, and a second spike on the 4th enabled cycle after refractory ends.
- Defaults; input=10 (-2) continuously -> v = -2, -3, ..., -8, -9, then holds at -9, no spike. With VW=4, v saturates at -8, no wrap to positive.
- Mid-REFRACT (counter=1), drive reset=0 for one edge -> next cycle state=INTEGRATE, in_refractory=0, v=0; integration restarts immediately.
- Enable toggling: input=01 with enable high only on every 3rd cycle -> v changes only on enabled edges; spike appears after the 4th enabled edge, single-cycle wide.
